// File: rtl/delay_tree_param.sv
// delay_tree_param: stallable shared delay chain with per-output programmable taps.
// A single MAX_DEPTH-stage register chain carries data plus a valid bit.
// Each of NUM_OUT outputs taps the chain through a combinational mux, so
// retargeting a tap exposes words that are already resident in the chain.
// Optional feature macro: DELAY_TREE_OCCUPANCY_EN enables the occupancy
// counter. When it is undefined, the occupancy port is tied to zero.
module delay_tree_param #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_DEPTH  = 8,
    parameter int unsigned NUM_OUT    = 4,
    localparam int unsigned SW        = $clog2(MAX_DEPTH),
    localparam int unsigned OW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          clr,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in,
    input  logic [NUM_OUT*SW-1:0]         cfg_tap,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out,
    output logic [NUM_OUT-1:0]            out_valid,
    output logic [OW-1:0]                 occupancy
);

    logic [DATA_WIDTH-1:0] d_q [MAX_DEPTH];
    logic [MAX_DEPTH-1:0]  v_q;

    // Data chain: shifts on every enabled cycle; data is never gated by valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(MAX_DEPTH); k++) begin
                d_q[k] <= '0;
            end
        end else if (en) begin
            d_q[0] <= in;
            for (int k = 1; k < int'(MAX_DEPTH); k++) begin
                d_q[k] <= d_q[k-1];
            end
        end
    end

    // Valid chain: flush wins over advance, and the incoming valid is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else if (clr) begin
            v_q <= '0;
        end else if (en) begin
            v_q <= {v_q[MAX_DEPTH-2:0], in_valid};
        end
    end

`ifdef DELAY_TREE_OCCUPANCY_EN
    logic [OW-1:0] occ_q;

    // Occupancy: one in, one out per enabled cycle; bounded by the chain length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (clr) begin
            occ_q <= '0;
        end else if (en) begin
            occ_q <= occ_q + OW'(in_valid) - OW'(v_q[MAX_DEPTH-1]);
        end
    end

    assign occupancy = occ_q;
`else
    assign occupancy = '0;
`endif

    // Per-output tap mux straight from the chain registers
    always_comb begin
        out       = '0;
        out_valid = '0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            out[i*DATA_WIDTH +: DATA_WIDTH] = d_q[cfg_tap[i*SW +: SW]];
            out_valid[i]                    = v_q[cfg_tap[i*SW +: SW]];
        end
    end

endmodule

// File: tb/tb_delay_tree_param.sv
// Self-checking bench for delay_tree_param.
// Reference model: a history of the words accepted on enabled edges, newest
// first. Tap t reads the entry accepted t+1 enabled edges ago, and occupancy
// is the number of valid entries in that history.
module tb_delay_tree_param;

    localparam int unsigned DW = 16;
    localparam int unsigned MD = 8;
    localparam int unsigned NO = 4;
    localparam int unsigned SW = $clog2(MD);
    localparam int unsigned OW = $clog2(MD + 1);

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               clr;
    logic               in_valid;
    logic [DW-1:0]      din;
    logic [NO*SW-1:0]   cfg_tap;
    logic [NO*DW-1:0]   out;
    logic [NO-1:0]      out_valid;
    logic [OW-1:0]      occupancy;

    int total;
    int bad;

    logic [DW-1:0] hist_d [$];
    logic          hist_v [$];

    delay_tree_param #(
        .DATA_WIDTH(DW),
        .MAX_DEPTH (MD),
        .NUM_OUT   (NO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (din),
        .cfg_tap  (cfg_tap),
        .out      (out),
        .out_valid(out_valid),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reset empties the history: every stage reads zero data, not valid
    task automatic model_reset();
        hist_d.delete();
        hist_v.delete();
        for (int k = 0; k < int'(MD); k++) begin
            hist_d.push_back('0);
            hist_v.push_back(1'b0);
        end
    endtask

    // Apply one rising edge to the model using the currently driven inputs
    task automatic model_edge();
        if (clr) begin
            for (int k = 0; k < int'(MD); k++) hist_v[k] = 1'b0;
        end
        if (en) begin
            hist_d.push_front(din);
            hist_v.push_front(in_valid && !clr);
            void'(hist_d.pop_back());
            void'(hist_v.pop_back());
        end
    endtask

    function automatic int model_occ();
        int n;
        n = 0;
`ifdef DELAY_TREE_OCCUPANCY_EN
        for (int k = 0; k < int'(MD); k++) n += int'(hist_v[k]);
`endif
        return n;
    endfunction

    // Compare every output and the occupancy against the model
    task automatic check_all(input string tag);
        int t;
        for (int i = 0; i < int'(NO); i++) begin
            t = int'(cfg_tap[i*SW +: SW]);
            check({tag, "_data"}, 64'(out[i*DW +: DW]), 64'(hist_d[t]));
            check({tag, "_valid"}, 64'(out_valid[i]), 64'(hist_v[t]));
        end
        check({tag, "_occ"}, 64'(occupancy), 64'(model_occ()));
    endtask

    // Drive inputs at the falling edge, clock once, check at the next falling edge
    task automatic cycle(input string tag, input logic e, input logic c,
                         input logic iv, input logic [DW-1:0] d);
        en       = e;
        clr      = c;
        in_valid = iv;
        din      = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    function automatic logic [NO*SW-1:0] taps(input int t0, input int t1, input int t2, input int t3);
        return {SW'(t3), SW'(t2), SW'(t1), SW'(t0)};
    endfunction

    int pulses [NO];
    int pulse_at [NO];

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        din      = '0;
        cfg_tap  = taps(0, 3, 5, 7);
        model_reset();

        #2;
        check("rst_out", 64'(out), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tap latency: one valid word, watch each output pulse once
        for (int i = 0; i < int'(NO); i++) begin
            pulses[i]   = 0;
            pulse_at[i] = -1;
        end
        cycle("lat_inj", 1'b1, 1'b0, 1'b1, 16'h00A5);
        for (int i = 0; i < int'(NO); i++) begin
            if (out_valid[i]) begin pulses[i]++; pulse_at[i] = 1; end
        end
        for (int n = 2; n <= 10; n++) begin
            cycle("lat_idle", 1'b1, 1'b0, 1'b0, 16'(n));
            for (int i = 0; i < int'(NO); i++) begin
                if (out_valid[i]) begin
                    pulses[i]++;
                    pulse_at[i] = n;
                    check("lat_word", 64'(out[i*DW +: DW]), 64'h00A5);
                end
            end
        end
        check("lat_cnt0", 64'(pulses[0]), 64'd1);
        check("lat_at0", 64'(pulse_at[0]), 64'd1);
        check("lat_at1", 64'(pulse_at[1]), 64'd4);
        check("lat_at2", 64'(pulse_at[2]), 64'd6);
        check("lat_at3", 64'(pulse_at[3]), 64'd8);

        // Stall: two words, three disabled cycles after the first edge
        cfg_tap = taps(2, 2, 2, 2);
        cycle("stall_w1", 1'b1, 1'b0, 1'b1, 16'h1111);
        for (int n = 0; n < 3; n++) cycle("stall_hold", 1'b0, 1'b0, 1'b1, 16'hDEAD);
        cycle("stall_w2", 1'b1, 1'b0, 1'b1, 16'h2222);
        cycle("stall_e3", 1'b1, 1'b0, 1'b0, 16'h0);
        check("stall_v1", 64'(out_valid[0]), 64'd1);
        check("stall_d1", 64'(out[DW-1:0]), 64'h1111);
        cycle("stall_e4", 1'b1, 1'b0, 1'b0, 16'h0);
        check("stall_v2", 64'(out_valid[0]), 64'd1);
        check("stall_d2", 64'(out[DW-1:0]), 64'h2222);
        for (int n = 0; n < 8; n++) cycle("stall_drain", 1'b1, 1'b0, 1'b0, 16'h0);

        // Flush: five words, then clr alongside a valid input
        cfg_tap = taps(0, 1, 4, 7);
        for (int n = 0; n < 5; n++) cycle("flush_fill", 1'b1, 1'b0, 1'b1, 16'(16'h0500 + n));
        cycle("flush_clr", 1'b1, 1'b1, 1'b1, 16'hBEEF);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_occ", 64'(occupancy), 64'd0);
        for (int n = 0; n < 9; n++) begin
            cycle("flush_after", 1'b1, 1'b0, 1'b0, 16'h0);
            check("flush_drop", 64'(out_valid), 64'd0);
        end

        // Occupancy saturation then drain
        for (int n = 0; n < 12; n++) cycle("sat_fill", 1'b1, 1'b0, 1'b1, 16'(16'h0C00 + n));
`ifdef DELAY_TREE_OCCUPANCY_EN
        check("sat_full", 64'(occupancy), 64'd8);
`else
        check("sat_full", 64'(occupancy), 64'd0);
`endif
        for (int n = 0; n < 9; n++) cycle("sat_drain", 1'b1, 1'b0, 1'b0, 16'h0);
        check("sat_empty", 64'(occupancy), 64'd0);

        // Live retap while stalled: W0..W7 resident, W7 newest at d[0]
        cfg_tap = taps(7, 0, 1, 3);
        for (int n = 0; n < 8; n++) cycle("retap_fill", 1'b1, 1'b0, 1'b1, 16'(16'h7700 + n));
        en = 1'b0;
        #1;
        check("retap_pre", 64'(out[DW-1:0]), 64'h7700);
        cfg_tap = taps(2, 0, 1, 3);
        #1;
        check("retap_d2", 64'(out[DW-1:0]), 64'h7705);
        check("retap_v2", 64'(out_valid[0]), 64'd1);
        @(negedge clk);
        for (int n = 0; n < 3; n++) cycle("retap_hold", 1'b0, 1'b0, 1'b1, 16'hFFFF);

        // Randomised traffic with live retapping
        for (int n = 0; n < 400; n++) begin
            cfg_tap = NO*SW'($urandom);
            cycle("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                  1'($urandom), DW'($urandom));
        end

        // Asynchronous reset mid-clock with a chain full of valids
        cfg_tap = taps(0, 2, 5, 7);
        for (int n = 0; n < 8; n++) cycle("rst_fill", 1'b1, 1'b0, 1'b1, 16'(16'hAB00 + n));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mrst_out", 64'(out), 64'd0);
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_occ", 64'(occupancy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) cycle("mrst_after", 1'b1, 1'b0, 1'b0, 16'(n));
        check("mrst_quiet", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delay_tree_param.md
# delay_tree_param

Parametrised, stallable delay line with per-output programmable tap depth and valid tracking. A single shared register chain of MAX_DEPTH stages carries data plus a valid bit. NUM_OUT outputs each select their own delay of 1..MAX_DEPTH enabled cycles. It sits between CGRA PE outputs and consumers to balance path latencies at configuration time, and freezes in place when the array stalls.

## Interface
Parameters:
- DATA_WIDTH, 16, data word width.
- MAX_DEPTH, 8, number of chain stages; power of two, ≥2.
- NUM_OUT, 4, number of independently tapped outputs.
- Derived: SW = $clog2(MAX_DEPTH) (tap select width); OW = $clog2(MAX_DEPTH+1) (occupancy width).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  advance chain this cycle; 0 = hold all state.
- clr  in  1  synchronous flush of all valid bits.
- in_valid  in  1  input word valid.
- in  in  DATA_WIDTH  input word.
- cfg_tap  in  NUM_OUT*SW  per-output tap; field i = bits [i*SW +: SW]; value t selects delay t+1.
- out  out  NUM_OUT*DATA_WIDTH  output i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  NUM_OUT  valid bit for output i.
- occupancy  out  OW  count of valid words resident in the chain.

## Operation
- State: data stages d[0..MAX_DEPTH-1], valid stages v[0..MAX_DEPTH-1], occupancy counter.
- en=1, clr=0: d[0]<=in, v[0]<=in_valid, d[k]<=d[k-1], v[k]<=v[k-1]; word leaving d[MAX_DEPTH-1] is discarded.
- en=0, clr=0: all data, valid and occupancy hold; in and in_valid are ignored.
- clr=1 (any en): all v[k]<=0, occupancy<=0; data shifts if en=1, else holds; in_valid that cycle is dropped. clr has priority over en for the valid bits.
- out_i = d[cfg_tap_i], out_valid_i = v[cfg_tap_i]; combinational mux from registers, no extra stage.
- cfg_tap may change in any cycle and takes effect immediately on the mux. The chain is unaffected, so no data is lost and retargeting a tap exposes already-resident words.
- Occupancy, when en=1 and clr=0: occ + in_valid − v[MAX_DEPTH-1]. Range is 0..MAX_DEPTH, never wraps.
- Data bits are not gated by valid: invalid words propagate as-is, and consumers qualify them with out_valid.

## Timing
- Reset (rst_n=0, asynchronous): all d[k]=0, v[k]=0, occupancy=0. Outputs therefore read out=0, out_valid=0 immediately, independent of clk.
- Reset deassertion is sampled synchronously at the next rising edge; the first update occurs on the first edge with rst_n=1.
- Latency for tap t: a word accepted on enabled edge n appears on out_i after edge n+t, i.e. exactly t+1 enabled edges after acceptance. Disabled cycles add delay 1:1.
- Throughput: one word per enabled cycle; no backpressure output.
- Reset mid-stream discards all resident words. Occupancy returns to 0 without underflow.

## Configuration
- Macro DELAY_TREE_OCCUPANCY_EN.
- Defined: occupancy counter implemented as specified.
- Undefined: counter logic removed; occupancy port still present and tied to 0. Data and valid behaviour are identical.

## Test plan
- Reset: assert rst_n=0 mid-clock with chain full of valids. Expect out=0, out_valid=0 and occupancy=0 before the next edge; after release with in_valid=0, they stay 0.
- Tap latency: en=1, cfg_tap fields {0,3,5,7}, inject 0x00A5 valid for 1 cycle. Expect out_valid_i high exactly 1, 4, 6, 8 edges later for one cycle each, each carrying 0x00A5.
- Stall: inject 0x1111, 0x2222 back-to-back with tap 2. Drop en for 3 cycles after the first edge. Expect outputs frozen during the stall, then 0x1111 and 0x2222 appear on consecutive cycles; total delay is 3+3 edges for 0x1111.
- Flush: fill with 5 valid words, then assert clr=1 with en=1 and in_valid=1. Expect all out_valid 0 next cycle, occupancy 0, and the dropped input never appears.
- Occupancy saturation (macro on): continuous in_valid for 12 cycles with MAX_DEPTH=8. Expect occupancy ramps 1..8 and holds at 8; after in_valid=0 it decrements to 0 over 8 cycles. With macro off, occupancy stays 0 throughout.
- Live retap: with words W0..W7 resident, change tap 0 from 7 to 2 while en=0. Expect out_0 to switch immediately to d[2] with the matching valid, and the chain contents unchanged.
